dpsk_nco: RTL and testbench

//  Numerically controlled oscillator; the stage directly downstream of the carrier-loop filter (lf).

---
 rtl/dpsk_nco.sv | 157 +++++++++++++++
 tb/tb_dpsk_nco.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dpsk_nco.sv
// dpsk_nco: carrier NCO; centre FCW plus shifted loop-filter correction drives a phase accumulator and quarter-wave sin/cos LUT.
// Latency: a sample strobed by clk_en in cycle n appears with nco_vld=1 in cycle n+3; one sample per cycle sustained.
// Backpressure: none; the pipeline free-runs every cycle and outputs hold between nco_vld pulses.
// Build options: `NCO_DITHER_EN adds a 16-bit LFSR phase dither before LUT addressing;
// `VCO_N sets the ctrl_in width (`VCO_N+1 bits), defaulting to 15 when not supplied by the build.

`ifndef VCO_N
`define VCO_N 15
`endif

module dpsk_nco #(
  parameter int               ACC_W      = 32,
  parameter logic [ACC_W-1:0] FCW_CENTER = 32'h4000_0000,
  parameter int               GAIN_SH    = 8,
  parameter int               LUT_AW     = 8,
  parameter int               OUT_W      = 12
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic signed [`VCO_N:0]  ctrl_in,
  output logic        [ACC_W-1:0] phase_o,
  output logic signed [OUT_W-1:0] nco_sin,
  output logic signed [OUT_W-1:0] nco_cos,
  output logic                    nco_vld
);

  localparam int               CTRL_W  = `VCO_N + 1;
  localparam int               LUT_N   = 2 ** LUT_AW;
  localparam int               TRUNC_W = ACC_W - 2 - LUT_AW;
  localparam logic [ACC_W-1:0] QUARTER = {2'b01, {(ACC_W-2){1'b0}}};
  localparam real              PI      = 3.14159265358979323846;
  localparam real              AMP     = real'((2 ** (OUT_W-1)) - 1);

  // Quarter-wave magnitude table, sampled at bin centres so no entry is zero.
  logic [OUT_W-2:0] lut_rom [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam real ANG = (PI / 2.0) * (real'(k) + 0.5) / real'(LUT_N);
    assign lut_rom[k] = (OUT_W-1)'($rtoi(AMP * $sin(ANG) + 0.5));
  end

  // Frequency word: sign-extended correction scaled by GAIN_SH, wrapping modulo 2**ACC_W.
  logic [ACC_W-1:0] ctrl_ext;
  logic [ACC_W-1:0] fcw;
  assign ctrl_ext = {{(ACC_W-CTRL_W){ctrl_in[CTRL_W-1]}}, ctrl_in};
  assign fcw      = FCW_CENTER + (ctrl_ext << GAIN_SH);

  logic [ACC_W-1:0] phase_acc;
  logic [ACC_W-1:0] s1_phase;
  logic             s1_vld;

  // S0: accumulate on each strobe and launch the pre-increment phase into the pipeline.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      phase_acc <= '0;
      s1_phase  <= '0;
      s1_vld    <= 1'b0;
    end else begin
      s1_vld <= clk_en;
      if (clk_en) begin
        s1_phase  <= phase_acc;
        phase_acc <= phase_acc + fcw;
      end
    end
  end

  logic [ACC_W-1:0] lut_phase;

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 in right-shift form, stepping once per strobe.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      lfsr <= 16'hACE1;
    end else if (clk_en) begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end
  end

  // Dither only perturbs the LUT address; phase_o keeps the clean phase.
  assign lut_phase = s1_phase + ACC_W'(lfsr);
`else
  assign lut_phase = s1_phase;
`endif

  // S1: quadrant and mirrored quarter-wave addresses; cosine is sine advanced by a quarter turn.
  logic [ACC_W-1:0]  cos_phase;
  logic [1:0]        sin_q;
  logic [1:0]        cos_q;
  logic [LUT_AW-1:0] sin_a;
  logic [LUT_AW-1:0] cos_a;
  logic [LUT_AW-1:0] sin_addr;
  logic [LUT_AW-1:0] cos_addr;
  logic              unused_trunc;

  assign cos_phase    = lut_phase + QUARTER;
  assign sin_q        = lut_phase[ACC_W-1 -: 2];
  assign cos_q        = cos_phase[ACC_W-1 -: 2];
  assign sin_a        = lut_phase[ACC_W-3 -: LUT_AW];
  assign cos_a        = cos_phase[ACC_W-3 -: LUT_AW];
  assign sin_addr     = sin_q[0] ? ~sin_a : sin_a;
  assign cos_addr     = cos_q[0] ? ~cos_a : cos_a;
  // Phase bits below the LUT address are deliberately truncated.
  assign unused_trunc = ^{lut_phase[TRUNC_W-1:0], cos_phase[TRUNC_W-1:0]};

  logic [OUT_W-2:0] s2_sin_mag;
  logic [OUT_W-2:0] s2_cos_mag;
  logic             s2_sin_neg;
  logic             s2_cos_neg;
  logic [ACC_W-1:0] s2_phase;
  logic             s2_vld;

  // S2: registered dual read of the magnitude table; sign comes from the upper quadrant bit.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      s2_sin_mag <= '0;
      s2_cos_mag <= '0;
      s2_sin_neg <= 1'b0;
      s2_cos_neg <= 1'b0;
      s2_phase   <= '0;
      s2_vld     <= 1'b0;
    end else begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_sin_mag <= lut_rom[sin_addr];
        s2_cos_mag <= lut_rom[cos_addr];
        s2_sin_neg <= sin_q[1];
        s2_cos_neg <= cos_q[1];
        s2_phase   <= s1_phase;
      end
    end
  end

  logic signed [OUT_W-1:0] sin_pos;
  logic signed [OUT_W-1:0] cos_pos;
  assign sin_pos = signed'({1'b0, s2_sin_mag});
  assign cos_pos = signed'({1'b0, s2_cos_mag});

  // S3: apply sign and publish; outputs only change on a valid sample.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      phase_o <= '0;
      nco_sin <= '0;
      nco_cos <= '0;
      nco_vld <= 1'b0;
    end else begin
      nco_vld <= s2_vld;
      if (s2_vld) begin
        phase_o <= s2_phase;
        nco_sin <= s2_sin_neg ? -sin_pos : sin_pos;
        nco_cos <= s2_cos_neg ? -cos_pos : cos_pos;
      end
    end
  end

endmodule

// File: tb/tb_dpsk_nco.sv
// tb_dpsk_nco: directed vectors for dpsk_nco in its default build (no dither, `VCO_N = 15).
// Each table row gives the inputs for one cycle and the outputs expected during that cycle.
// Expected sin/cos values are hand-evaluated from the LUT formula for the phases reached.

`ifndef VCO_N
`define VCO_N 15
`endif

module tb_dpsk_nco;

  logic                   sys_clk = 1'b0;
  logic                   rst_n;
  logic                   clk_en;
  logic signed [`VCO_N:0] ctrl_in;
  logic [31:0]            phase_o;
  logic signed [11:0]     nco_sin;
  logic signed [11:0]     nco_cos;
  logic                   nco_vld;

  dpsk_nco dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .clk_en  (clk_en),
    .ctrl_in (ctrl_in),
    .phase_o (phase_o),
    .nco_sin (nco_sin),
    .nco_cos (nco_cos),
    .nco_vld (nco_vld)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic                   en;
    logic signed [`VCO_N:0] ctrl;
    logic                   vld;
    logic [31:0]            ph;
    int                     s;
    int                     c;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic en, input logic signed [`VCO_N:0] ctrl, input logic vld,
                     input logic [31:0] ph, input int s, input int c);
    vec_t v;
    v.en = en; v.ctrl = ctrl; v.vld = vld; v.ph = ph; v.s = s; v.c = c;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld, input logic [31:0] ph,
                         input int s, input int c);
    chk({tag, " nco_vld"}, longint'(nco_vld), longint'(vld));
    chk({tag, " phase_o"}, longint'(phase_o), longint'(ph));
    chk({tag, " nco_sin"}, longint'(nco_sin), longint'(s));
    chk({tag, " nco_cos"}, longint'(nco_cos), longint'(c));
  endtask

  task automatic step(input logic r, input logic en, input logic signed [`VCO_N:0] ctrl);
    rst_n = r; clk_en = en; ctrl_in = ctrl;
  endtask

  logic signed [`VCO_N:0] cmin;
  logic signed [`VCO_N:0] cjunk;

  initial begin
    cmin  = {1'b1, {`VCO_N{1'b0}}};
    cjunk = {1'b0, {`VCO_N{1'b1}}};

    // Free-running carrier (ctrl 0), then +1 and -1 corrections, then most-negative
    // correction wrapping through 2^32, then drain.
    add(1, 0,    0, 32'h0000_0000,     0,     0);
    add(1, 0,    0, 32'h0000_0000,     0,     0);
    add(1, 0,    0, 32'h0000_0000,     0,     0);
    add(1, 0,    1, 32'h0000_0000,     6,  2047);
    add(1, 1,    1, 32'h4000_0000,  2047,    -6);
    add(1, 1,    1, 32'h8000_0000,    -6, -2047);
    add(1, 1,    1, 32'hC000_0000, -2047,     6);
    add(1, 1,    1, 32'h0000_0000,     6,  2047);
    add(1, -1,   1, 32'h4000_0100,  2047,    -6);
    add(1, -1,   1, 32'h8000_0200,    -6, -2047);
    add(1, -1,   1, 32'hC000_0300, -2047,     6);
    add(1, -1,   1, 32'h0000_0400,     6,  2047);
    add(1, cmin, 1, 32'h4000_0300,  2047,    -6);
    add(1, cmin, 1, 32'h8000_0200,    -6, -2047);
    add(1, cmin, 1, 32'hC000_0100, -2047,     6);
    add(1, cmin, 1, 32'h0000_0000,     6,  2047);
    add(1, cmin, 1, 32'h3F80_0000,  2047,    19);
    add(1, cmin, 1, 32'h7F00_0000,    44, -2047);
    add(0, 0,    1, 32'hBE80_0000, -2046,   -69);
    add(0, 0,    1, 32'hFE00_0000,   -94,  2045);
    add(0, 0,    1, 32'h3D80_0000,  2044,   119);
    add(0, 0,    0, 32'h3D80_0000,  2044,   119);
    // One strobe in four; ctrl_in carries junk while clk_en is low.
    for (int j = 0; j < 12; j++) begin
      logic        en;
      logic [31:0] ph;
      int          s;
      int          c;
      en = (j % 4 == 0);
      if (j < 3)       begin ph = 32'h3D80_0000; s = 2044;  c = 119;   end
      else if (j < 7)  begin ph = 32'h7D00_0000; s = 144;   c = -2042; end
      else if (j < 11) begin ph = 32'hBD00_0000; s = -2042; c = -144;  end
      else             begin ph = 32'hFD00_0000; s = -144;  c = 2042;  end
      add(en, en ? '0 : cjunk, (j % 4 == 3), ph, s, c);
    end

    // Reset state.
    step(0, 0, 0);
    repeat (3) @(negedge sys_clk);
    chk_out("reset", 0, 32'h0, 0, 0);

    foreach (vq[i]) begin
      step(1, vq[i].en, vq[i].ctrl);
      chk_out($sformatf("vec%0d", i), vq[i].vld, vq[i].ph, vq[i].s, vq[i].c);
      @(negedge sys_clk);
    end

    // Reset while samples are in flight: nothing from before reset may emerge.
    step(1, 1, 0);
    chk_out("rst c0", 0, 32'hFD00_0000, -144, 2042);
    @(negedge sys_clk);
    step(1, 1, 0);
    chk("rst c1 nco_vld", longint'(nco_vld), 0);
    @(negedge sys_clk);
    step(0, 1, 0);
    chk("rst c2 nco_vld", longint'(nco_vld), 0);
    @(negedge sys_clk);
    step(1, 0, cjunk);
    chk_out("rst c3", 0, 32'h0, 0, 0);
    for (int k = 4; k < 7; k++) begin
      @(negedge sys_clk);
      chk($sformatf("rst c%0d nco_vld", k), longint'(nco_vld), 0);
    end
    @(negedge sys_clk);
    step(1, 1, 0);
    chk("rst c7 nco_vld", longint'(nco_vld), 0);
    @(negedge sys_clk);
    step(1, 0, cjunk);
    chk("rst c8 nco_vld", longint'(nco_vld), 0);
    @(negedge sys_clk);
    chk("rst c9 nco_vld", longint'(nco_vld), 0);
    @(negedge sys_clk);
    chk_out("rst c10", 1, 32'h0, 6, 2047);
    @(negedge sys_clk);
    chk_out("rst c11", 0, 32'h0, 6, 2047);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
